// File: rtl/qbu_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qbu_rx_pkg
// Purpose  : Shared types and constants for the Qbu RX frame arbiter
//            (FSM state encoding, source tags, user source-bit position).
// Revision : 1.0 - initial release
// ============================================================================
package qbu_rx_pkg;

    // Arbiter FSM states: arbitration happens only in ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMAC = 2'd1,
        ST_PMAC = 2'd2
    } state_e;

    // Source tag carried in the merged stream's user sideband
    localparam logic SRC_EMAC     = 1'b0;
    localparam logic SRC_PMAC     = 1'b1;
    localparam int   USER_SRC_BIT = 15;

    // Build the merged user word: source tag on top, source user bits below
    function automatic logic [15:0] tag_user(input logic src, input logic [14:0] user_lo);
        logic [15:0] u;
        u                  = '0;
        u[USER_SRC_BIT]    = src;
        u[USER_SRC_BIT-1:0] = user_lo;
        return u;
    endfunction

endpackage : qbu_rx_pkg
`default_nettype wire

// File: rtl/qbu_rx_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : qbu_rx_out_slot
// Purpose  : Single-entry registered AXI-Stream output stage. A load always
//            wins over a drain, so a beat accepted downstream can be replaced
//            by a new one in the same cycle without a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module qbu_rx_out_slot #(
    parameter int DWIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DWIDTH-1:0]     i_data,
    input  logic [15:0]           i_user,
    input  logic [DWIDTH/8-1:0]   i_keep,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic [DWIDTH-1:0]     o_data,
    output logic [15:0]           o_user,
    output logic [DWIDTH/8-1:0]   o_keep,
    output logic                  o_last,
    output logic                  o_valid
);

    logic [DWIDTH-1:0]   data_q;
    logic [15:0]         user_q;
    logic [DWIDTH/8-1:0] keep_q;
    logic                last_q;
    logic                valid_q;

    // Load a new beat, otherwise hold while stalled or drop valid once drained
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            user_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (i_load) begin
            data_q  <= i_data;
            user_q  <= i_user;
            keep_q  <= i_keep;
            last_q  <= i_last;
            valid_q <= 1'b1;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_data  = data_q;
    assign o_user  = user_q;
    assign o_keep  = keep_q;
    assign o_last  = last_q;
    assign o_valid = valid_q;

endmodule : qbu_rx_out_slot
`default_nettype wire

// File: rtl/qbu_rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qbu_rx_frame_arbiter
// Purpose  : Frame-atomic arbiter merging the eMAC and pMAC receive streams
//            into one Qbu RX stream. Express priority with a pMAC starvation
//            guard, or round-robin. Tags source in user[15], counts frames.
// Revision : 1.0 - initial release
// ============================================================================
module qbu_rx_frame_arbiter
    import qbu_rx_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_arb_mode,
    input  logic [DWIDTH-1:0]     i_emac_axis_data,
    input  logic [15:0]           i_emac_axis_user,
    input  logic [DWIDTH/8-1:0]   i_emac_axis_keep,
    input  logic                  i_emac_axis_last,
    input  logic                  i_emac_axis_valid,
    output logic                  o_emac_axis_ready,
    input  logic [DWIDTH-1:0]     i_pmac_axis_data,
    input  logic [15:0]           i_pmac_axis_user,
    input  logic [DWIDTH/8-1:0]   i_pmac_axis_keep,
    input  logic                  i_pmac_axis_last,
    input  logic                  i_pmac_axis_valid,
    output logic                  o_pmac_axis_ready,
    output logic [DWIDTH-1:0]     o_qbu_rx_axis_data,
    output logic [15:0]           o_qbu_rx_axis_user,
    output logic [DWIDTH/8-1:0]   o_qbu_rx_axis_keep,
    output logic                  o_qbu_rx_axis_last,
    output logic                  o_qbu_rx_axis_valid,
    input  logic                  i_qbu_rx_axis_ready,
    output logic                  o_grant_emac,
    output logic                  o_grant_pmac,
    output logic [CNT_W-1:0]      o_emac_frame_cnt,
    output logic [CNT_W-1:0]      o_pmac_frame_cnt
);

    // Starvation counter only needs to reach STARVE_LIMIT
    localparam int          SW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] c_LIMIT = SW'(STARVE_LIMIT);
    localparam bit          c_GUARD_EN = (STARVE_LIMIT != 0);

    state_e             state_q, state_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               rr_emac_last_q, rr_emac_last_d;
    logic [CNT_W-1:0]   emac_cnt_q, emac_cnt_d;
    logic [CNT_W-1:0]   pmac_cnt_q, pmac_cnt_d;

    logic               w_idle;
    logic               w_pick_pmac;
    logic               w_grant_emac;
    logic               w_grant_pmac;
    logic               w_slot_free;
    logic               w_emac_acc;
    logic               w_pmac_acc;
    logic               w_load;
    logic [DWIDTH-1:0]  w_ld_data;
    logic [15:0]        w_ld_user;
    logic [DWIDTH/8-1:0] w_ld_keep;
    logic               w_ld_last;
    logic               w_out_valid;
    logic               w_unused_user;

    // Incoming user[15] is replaced by the source tag
    assign w_unused_user = i_emac_axis_user[15] ^ i_pmac_axis_user[15];

    // Frame-level arbitration; grants are masked while reset is asserted
    always_comb begin
        w_idle      = (state_q == ST_IDLE) && i_rst_n;
        w_pick_pmac = i_arb_mode ? rr_emac_last_q
                                 : (c_GUARD_EN && (starve_q >= c_LIMIT));
        w_grant_emac = w_idle && i_emac_axis_valid && (!i_pmac_axis_valid || !w_pick_pmac);
        w_grant_pmac = w_idle && i_pmac_axis_valid && (!i_emac_axis_valid || w_pick_pmac);
    end

    assign o_grant_emac = w_grant_emac;
    assign o_grant_pmac = w_grant_pmac;

    // Ready only for the granted source, and only when the slot can take a beat
    assign w_slot_free       = !w_out_valid || i_qbu_rx_axis_ready;
    assign o_emac_axis_ready = (state_q == ST_EMAC) && w_slot_free;
    assign o_pmac_axis_ready = (state_q == ST_PMAC) && w_slot_free;
    assign w_emac_acc        = i_emac_axis_valid && o_emac_axis_ready;
    assign w_pmac_acc        = i_pmac_axis_valid && o_pmac_axis_ready;

    // Select the beat to load into the output slot from the granted source
    always_comb begin
        w_load    = 1'b0;
        w_ld_data = i_emac_axis_data;
        w_ld_keep = i_emac_axis_keep;
        w_ld_last = i_emac_axis_last;
        w_ld_user = tag_user(SRC_EMAC, i_emac_axis_user[14:0]);
        if (w_pmac_acc) begin
            w_load    = 1'b1;
            w_ld_data = i_pmac_axis_data;
            w_ld_keep = i_pmac_axis_keep;
            w_ld_last = i_pmac_axis_last;
            w_ld_user = tag_user(SRC_PMAC, i_pmac_axis_user[14:0]);
        end else if (w_emac_acc) begin
            w_load    = 1'b1;
        end
    end

    // Next state, starvation guard, round-robin pointer and frame counters
    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        rr_emac_last_d = rr_emac_last_q;
        emac_cnt_d     = emac_cnt_q;
        pmac_cnt_d     = pmac_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_emac) begin
                    state_d        = ST_EMAC;
                    rr_emac_last_d = 1'b1;
                    if (i_pmac_axis_valid && (starve_q != c_LIMIT))
                        starve_d = starve_q + 1'b1;
                end else if (w_grant_pmac) begin
                    state_d        = ST_PMAC;
                    rr_emac_last_d = 1'b0;
                    starve_d       = '0;
                end
            end
            ST_EMAC: begin
                if (w_emac_acc && i_emac_axis_last) begin
                    state_d    = ST_IDLE;
                    emac_cnt_d = emac_cnt_q + 1'b1;
                end
            end
            ST_PMAC: begin
                if (w_pmac_acc && i_pmac_axis_last) begin
                    state_d    = ST_IDLE;
                    pmac_cnt_d = pmac_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            starve_q       <= '0;
            rr_emac_last_q <= 1'b0;
            emac_cnt_q     <= '0;
            pmac_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            rr_emac_last_q <= rr_emac_last_d;
            emac_cnt_q     <= emac_cnt_d;
            pmac_cnt_q     <= pmac_cnt_d;
        end
    end

    assign o_emac_frame_cnt = emac_cnt_q;
    assign o_pmac_frame_cnt = pmac_cnt_q;

    qbu_rx_out_slot #(
        .DWIDTH (DWIDTH)
    ) u_out_slot (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_data  (w_ld_data),
        .i_user  (w_ld_user),
        .i_keep  (w_ld_keep),
        .i_last  (w_ld_last),
        .i_ready (i_qbu_rx_axis_ready),
        .o_data  (o_qbu_rx_axis_data),
        .o_user  (o_qbu_rx_axis_user),
        .o_keep  (o_qbu_rx_axis_keep),
        .o_last  (o_qbu_rx_axis_last),
        .o_valid (w_out_valid)
    );

    assign o_qbu_rx_axis_valid = w_out_valid;

endmodule : qbu_rx_frame_arbiter
`default_nettype wire
